pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_stack_if.sv | 35 +++
 rtl/pc_stack_unit.sv | 136 +++++++++++++
 tb/tb_pc_stack_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_stack_if.sv
// Bundle between the fetch controller and pc_stack_unit.
// master: controller side (drives stall, instruction, pc_src, push/pop, target).
// slave : pc_stack_unit side (drives pc, ret_addr, depth, halted and,
//         with PC_STACK_ERR_EN defined, the sticky stack_ovf/stack_unf flags).
interface pc_stack_if #(
    parameter int unsigned PC_W  = 12,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned DEPTH_W = $clog2(DEPTH) + 1;

    logic                stall;
    logic [18:0]         instruction;
    logic [1:0]          pc_src;
    logic                stack_push;
    logic                stack_pop;
    logic [PC_W-1:0]     target;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     ret_addr;
    logic [DEPTH_W-1:0]  depth;
    logic                halted;
`ifdef PC_STACK_ERR_EN
    logic                stack_ovf;
    logic                stack_unf;

    modport master (output stall, instruction, pc_src, stack_push, stack_pop, target,
                    input  pc, ret_addr, depth, halted, stack_ovf, stack_unf);
    modport slave  (input  stall, instruction, pc_src, stack_push, stack_pop, target,
                    output pc, ret_addr, depth, halted, stack_ovf, stack_unf);
`else
    modport master (output stall, instruction, pc_src, stack_push, stack_pop, target,
                    input  pc, ret_addr, depth, halted);
    modport slave  (input  stall, instruction, pc_src, stack_push, stack_pop, target,
                    output pc, ret_addr, depth, halted);
`endif
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a hardware return-address stack and sticky halt.
// Ports: clk, rst_n (async active-low), bus (pc_stack_if.slave).
// Optional macro PC_STACK_ERR_EN: saturating stack with sticky stack_ovf /
// stack_unf flags; when undefined the stack pointer wraps modulo DEPTH.
// DEPTH must be a power of two and at least 2.
module pc_stack_unit #(
    parameter int unsigned PC_W  = 12,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_stack_if.slave    bus
);
    localparam int unsigned SP_W    = $clog2(DEPTH);
    localparam int unsigned DEPTH_W = SP_W + 1;
    localparam logic [18:0] HALT_WORD = 19'h7FFFF;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               halted_q, halted_d;
    logic               mem_we;
    logic [PC_W-1:0]    mem [DEPTH];

    logic [PC_W-1:0]    pc_inc;
    logic [SP_W-1:0]    sp_dec;
    logic               full, empty;

    assign pc_inc = pc_q + PC_W'(1);
    assign sp_dec = sp_q - SP_W'(1);
    assign full   = (depth_q == DEPTH_W'(DEPTH));
    assign empty  = (depth_q == '0);

`ifdef PC_STACK_ERR_EN
    logic ovf_q, ovf_d, unf_q, unf_d;
`endif

    // Next-state selection; halt wins over any pc_src action on the same edge.
    always_comb begin
        pc_d     = pc_q;
        sp_d     = sp_q;
        depth_d  = depth_q;
        halted_d = halted_q;
        mem_we   = 1'b0;
`ifdef PC_STACK_ERR_EN
        ovf_d    = ovf_q;
        unf_d    = unf_q;
`endif
        if (!bus.stall && !halted_q) begin
            if (bus.instruction == HALT_WORD) begin
                halted_d = 1'b1;
            end else begin
                case (bus.pc_src)
                    2'b01: begin
                        pc_d = bus.target;
                        if (bus.stack_push) begin
`ifdef PC_STACK_ERR_EN
                            if (full) begin
                                ovf_d = 1'b1;
                            end else begin
                                mem_we  = 1'b1;
                                sp_d    = sp_q + SP_W'(1);
                                depth_d = depth_q + DEPTH_W'(1);
                            end
`else
                            // Wrap: overwrite the oldest entry, depth saturates.
                            mem_we = 1'b1;
                            sp_d   = sp_q + SP_W'(1);
                            if (!full) depth_d = depth_q + DEPTH_W'(1);
`endif
                        end
                    end
                    2'b10: begin
                        if (bus.stack_pop) begin
`ifdef PC_STACK_ERR_EN
                            if (empty) begin
                                pc_d  = pc_inc;
                                unf_d = 1'b1;
                            end else begin
                                pc_d    = mem[sp_dec];
                                sp_d    = sp_dec;
                                depth_d = depth_q - DEPTH_W'(1);
                            end
`else
                            // Wrap: an empty pop still reads below sp, depth stays 0.
                            pc_d = mem[sp_dec];
                            sp_d = sp_dec;
                            if (!empty) depth_d = depth_q - DEPTH_W'(1);
`endif
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                    default: pc_d = pc_inc;
                endcase
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            sp_q     <= '0;
            depth_q  <= '0;
            halted_q <= 1'b0;
`ifdef PC_STACK_ERR_EN
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
`endif
        end else begin
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            depth_q  <= depth_d;
            halted_q <= halted_d;
`ifdef PC_STACK_ERR_EN
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
`endif
        end
    end

    // Stack storage is never reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem[sp_q] <= pc_inc;
    end

    assign bus.pc       = pc_q;
    assign bus.ret_addr = mem[sp_dec];
    assign bus.depth    = depth_q;
    assign bus.halted   = halted_q;
`ifdef PC_STACK_ERR_EN
    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;
`endif
endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios plus random
// stimulus, all checked against a behavioural stack model.
module tb_pc_stack_unit;
    localparam int unsigned PC_W  = 12;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PCM   = 1 << PC_W;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pc_stack_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();
    pc_stack_unit #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Reference model: a circular array with an integer pointer.
    int unsigned m_pc, m_sp, m_depth;
    bit          m_halted, m_ovf, m_unf;
    int unsigned m_stk [DEPTH];
    int unsigned ra [9];

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_sp = 0; m_depth = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_edge(input bit st, input logic [18:0] ins, input logic [1:0] src,
                              input bit pu, input bit po, input int unsigned tgt);
        if (st || m_halted) return;
        if (ins == 19'h7FFFF) begin
            m_halted = 1;
        end else if (src == 2'd1) begin
            if (pu) begin
`ifdef PC_STACK_ERR_EN
                if (m_depth == DEPTH) m_ovf = 1;
                else begin
                    m_stk[m_sp] = (m_pc + 1) % PCM;
                    m_sp = (m_sp + 1) % DEPTH;
                    m_depth++;
                end
`else
                m_stk[m_sp] = (m_pc + 1) % PCM;
                m_sp = (m_sp + 1) % DEPTH;
                if (m_depth < DEPTH) m_depth++;
`endif
            end
            m_pc = tgt % PCM;
        end else if (src == 2'd2 && po) begin
`ifdef PC_STACK_ERR_EN
            if (m_depth == 0) begin
                m_pc = (m_pc + 1) % PCM;
                m_unf = 1;
            end else begin
                m_sp = (m_sp + DEPTH - 1) % DEPTH;
                m_pc = m_stk[m_sp];
                m_depth--;
            end
`else
            m_sp = (m_sp + DEPTH - 1) % DEPTH;
            m_pc = m_stk[m_sp];
            if (m_depth > 0) m_depth--;
`endif
        end else begin
            m_pc = (m_pc + 1) % PCM;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, 32'(bus.pc), m_pc);
        chk({tag, ".depth"}, 32'(bus.depth), m_depth);
        chk({tag, ".halted"}, 32'(bus.halted), 32'(m_halted));
        if (m_depth > 0)
            chk({tag, ".ret"}, 32'(bus.ret_addr), m_stk[(m_sp + DEPTH - 1) % DEPTH]);
`ifdef PC_STACK_ERR_EN
        chk({tag, ".ovf"}, 32'(bus.stack_ovf), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(bus.stack_unf), 32'(m_unf));
`endif
    endtask

    // Drive one cycle's inputs, advance the model, check #1 after the edge.
    task automatic step(input string tag, input bit st, input logic [18:0] ins,
                        input logic [1:0] src, input bit pu, input bit po, input int unsigned tgt);
        bus.stall       = st;
        bus.instruction = ins;
        bus.pc_src      = src;
        bus.stack_push  = pu;
        bus.stack_pop   = po;
        bus.target      = PC_W'(tgt);
        model_edge(st, ins, src, pu, po, tgt);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    int unsigned saved_pc, saved_depth, expect_pc;

    initial begin
        bus.stall = 0; bus.instruction = '0; bus.pc_src = 2'd0;
        bus.stack_push = 0; bus.stack_pop = 0; bus.target = '0;
        #1 rst_n = 1'b0;
        model_reset();
        #11;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Five sequential edges.
        for (int i = 0; i < 5; i++) step("seq", 0, 19'd0, 2'd0, 0, 0, 0);
        chk("seq5.pc", 32'(bus.pc), 5);

        // Single call and return.
        step("jmp10", 0, 19'd0, 2'd1, 0, 0, 'h010);
        step("call", 0, 19'd0, 2'd1, 1, 0, 'h200);
        chk("call.pc", 32'(bus.pc), 'h200);
        chk("call.ret", 32'(bus.ret_addr), 'h011);
        step("ret", 0, 19'd0, 2'd2, 0, 1, 0);
        chk("ret.pc", 32'(bus.pc), 'h011);
        chk("ret.depth", 32'(bus.depth), 0);

        // Nine nested calls, then eight returns.
        for (int i = 0; i < 9; i++) begin
            ra[i] = (m_pc + 1) % PCM;
            step("ncall", 0, 19'd0, 2'd1, 1, 0, 'h100 + i * 'h10);
        end
        chk("nest.depth", 32'(bus.depth), DEPTH);
        chk("nest.pc", 32'(bus.pc), 'h180);
        for (int i = 0; i < 8; i++) begin
            step("nret", 0, 19'd0, 2'd2, 0, 1, 0);
`ifdef PC_STACK_ERR_EN
            chk("nret.addr", 32'(bus.pc), ra[7 - i]);
`else
            chk("nret.addr", 32'(bus.pc), ra[8 - i]);
`endif
        end

        // Asynchronous reset pulse between edges at depth 3.
        for (int i = 0; i < 3; i++) step("pre_rst", 0, 19'd0, 2'd1, 1, 0, 'h300 + i);
        chk("pre_rst.depth", 32'(bus.depth), 3);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst.pc", 32'(bus.pc), 0);
        chk("async_rst.depth", 32'(bus.depth), 0);
        #2 rst_n = 1'b1;
        step("post_rst", 0, 19'd0, 2'd0, 0, 0, 0);
        chk("post_rst.pc", 32'(bus.pc), 1);

        // Pop at empty from 0x030.
        step("jmp30", 0, 19'd0, 2'd1, 0, 0, 'h030);
`ifdef PC_STACK_ERR_EN
        expect_pc = 'h031;
`else
        expect_pc = m_stk[DEPTH - 1];
`endif
        step("unf", 0, 19'd0, 2'd2, 0, 1, 0);
        chk("unf.pc", 32'(bus.pc), expect_pc);
        chk("unf.depth", 32'(bus.depth), 0);

        // Call from the top address pushes 0.
        step("jmpfff", 0, 19'd0, 2'd1, 0, 0, 'hFFF);
        step("wcall", 0, 19'd0, 2'd1, 1, 0, 'h050);
        chk("wcall.ret", 32'(bus.ret_addr), 0);
        step("wret", 0, 19'd0, 2'd2, 0, 1, 0);
        chk("wret.pc", 32'(bus.pc), 0);

        // Random traffic, never issuing the halt word.
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 7) == 0), 19'($urandom) & 19'h7FFFE,
                 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 $urandom_range(0, PCM - 1));
        end

        // Stall freezes everything for three edges.
        saved_pc = m_pc;
        saved_depth = m_depth;
        for (int i = 0; i < 3; i++) step("stall", 1, 19'd0, 2'd1, 1, 0, 'h3AB);
        chk("stall.pc", 32'(bus.pc), saved_pc);
        chk("stall.depth", 32'(bus.depth), saved_depth);

        // Halt beats a simultaneous call.
        step("jmp44", 0, 19'd0, 2'd1, 0, 0, 'h044);
        saved_depth = m_depth;
        step("halt", 0, 19'h7FFFF, 2'd1, 1, 0, 'h123);
        chk("halt.pc", 32'(bus.pc), 'h044);
        chk("halt.depth", 32'(bus.depth), saved_depth);
        chk("halt.flag", 32'(bus.halted), 1);
        for (int i = 0; i < 3; i++) step("halted", 0, 19'd0, 2'd0, 0, 0, 0);
        chk("halted.pc", 32'(bus.pc), 'h044);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
